// File: rtl/data_mem_resp.sv
// Wait-stated RV32I data memory responder: one access at a time, fixed latency, byte/half/word lanes.
// Optional DMEM_MISALIGN_CHK_EN turns misaligned half/word accesses into errors instead of aligning them.
module data_mem_resp #(
  parameter int ADDR_W      = 9,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);
  localparam int DEPTH = 2 ** (ADDR_W - 2);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;
  localparam logic [3:0] LAST_WAIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_f3;
  logic [31:0]       r_wdata;
  logic              r_rsp_valid;
  logic [31:0]       r_rdata;
  logic              r_err;
  logic [31:0]       r_mem [DEPTH];

  logic              w_idle, w_accept, w_enter_resp, w_mem_we;
  logic              w_we, w_err, w_bad_f3, w_size_h, w_size_w;
  logic [ADDR_W-1:0] w_addr;
  logic [2:0]        w_f3;
  logic [31:0]       w_wdata, w_word, w_load, w_wd;
  logic [1:0]        w_off;
  logic [3:0]        w_be;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [ADDR_W-3:0] w_idx;

  assign w_idle    = (r_state == S_IDLE);
  assign req_ready = w_idle & ~reset;
  assign w_accept  = req_valid & req_ready;

  // With zero wait states the access completes on the accept edge, so it must use the live inputs.
  assign w_we    = w_idle ? req_we     : r_we;
  assign w_addr  = w_idle ? req_addr   : r_addr;
  assign w_f3    = w_idle ? req_funct3 : r_f3;
  assign w_wdata = w_idle ? req_wdata  : r_wdata;

  assign w_enter_resp = (w_accept && (WAIT_CYCLES == 0)) ||
                        ((r_state == S_WAIT) && (r_cnt == LAST_WAIT));

  assign w_idx  = w_addr[ADDR_W-1:2];
  assign w_word = r_mem[w_idx];

  always_comb begin
    w_size_h = (w_f3[1:0] == 2'b01);
    w_size_w = (w_f3[1:0] == 2'b10);
    if (w_we) w_bad_f3 = w_f3[2] | (w_f3[1:0] == 2'b11);
    else      w_bad_f3 = (w_f3[1:0] == 2'b11) | (w_f3 == 3'b110);
`ifdef DMEM_MISALIGN_CHK_EN
    w_err = w_bad_f3 | (w_size_h & w_addr[0]) | (w_size_w & (|w_addr[1:0]));
`else
    w_err = w_bad_f3;
`endif
    w_off = w_size_w ? 2'b00 : (w_size_h ? {w_addr[1], 1'b0} : w_addr[1:0]);
  end

  always_comb begin
    w_byte = w_word[{w_off, 3'b000} +: 8];
    w_half = w_off[1] ? w_word[31:16] : w_word[15:0];
    case (w_f3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'd0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = w_word;
    endcase
  end

  always_comb begin
    case (w_f3[1:0])
      2'b00: begin
        w_be = 4'b0001 << w_off;
        w_wd = {4{w_wdata[7:0]}};
      end
      2'b01: begin
        w_be = w_off[1] ? 4'b1100 : 4'b0011;
        w_wd = {2{w_wdata[15:0]}};
      end
      default: begin
        w_be = 4'b1111;
        w_wd = w_wdata;
      end
    endcase
  end

  assign w_mem_we = w_enter_resp & w_we & ~w_err & ~reset;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wd[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_f3        <= '0;
      r_wdata     <= '0;
      r_rsp_valid <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_rsp_valid <= w_enter_resp;
      if (w_enter_resp) begin
        r_rdata <= (w_we | w_err) ? '0 : w_load;
        r_err   <= w_err;
      end
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_f3    <= req_funct3;
            r_wdata <= req_wdata;
            r_cnt   <= '0;
            r_state <= (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
          end
        end
        S_WAIT: begin
          if (r_cnt == LAST_WAIT) r_state <= S_RESP;
          else                    r_cnt   <= r_cnt + 4'd1;
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;
endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp: directed cases plus random traffic against a byte-level memory model.
// Expectations follow DMEM_MISALIGN_CHK_EN when it is defined.
module tb_data_mem_resp;
  localparam int AW = 9;
  localparam int WC = 2;

  logic          clk = 1'b0;
  logic          reset, req_valid, req_we, req_ready, rsp_valid, rsp_err;
  logic [AW-1:0] req_addr;
  logic [2:0]    req_funct3;
  logic [31:0]   req_wdata, rsp_rdata;

  int total = 0;
  int bad   = 0;
  logic [31:0] m_mem [128];

  always #5 clk = ~clk;

  data_mem_resp #(.ADDR_W(AW), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: access size from funct3, then byte-by-byte arithmetic on the word array.
  task automatic model_op(input logic we, input logic [AW-1:0] a, input logic [2:0] f3,
                          input logic [31:0] wd, output logic err, output logic [31:0] rd);
    int unsigned idx, off, size, sh;
    bit sgn;
    logic [63:0] mask;
    logic [31:0] w;
    idx = a >> 2; off = a % 4; err = 1'b0; rd = '0; sgn = 1'b0; size = 4;
    if (we) begin
      case (f3)
        3'd0: size = 1;
        3'd1: size = 2;
        3'd2: size = 4;
        default: err = 1'b1;
      endcase
    end else begin
      case (f3)
        3'd0: begin size = 1; sgn = 1'b1; end
        3'd1: begin size = 2; sgn = 1'b1; end
        3'd2: size = 4;
        3'd4: size = 1;
        3'd5: size = 2;
        default: err = 1'b1;
      endcase
    end
    if (!err && (off % size) != 0) begin
`ifdef DMEM_MISALIGN_CHK_EN
      err = 1'b1;
`else
      off = off - (off % size);
`endif
    end
    if (err) return;
    w = m_mem[idx];
    if (we) begin
      for (int unsigned b = 0; b < size; b++) begin
        sh = 8 * (off + b);
        w = (w & ~(32'hFF << sh)) | (((wd >> (8 * b)) & 32'hFF) << sh);
      end
      m_mem[idx] = w;
    end else begin
      mask = (64'd1 << (8 * size)) - 64'd1;
      rd = (w >> (8 * off)) & mask[31:0];
      if (sgn && rd[8*size-1]) rd = rd | ~mask[31:0];
    end
  endtask

  // Starts in IDLE just after a falling edge; ends the same way one cycle after the response.
  task automatic txn(input logic we, input logic [AW-1:0] a, input logic [2:0] f3,
                     input logic [31:0] wd, input string tag,
                     output logic [31:0] rd_obs, output logic err_obs);
    logic e_err;
    logic [31:0] e_rd;
    int n;
    bit got, busy_bad;
    model_op(we, a, f3, wd, e_err, e_rd);
    req_valid = 1'b1; req_we = we; req_addr = a; req_funct3 = f3; req_wdata = wd;
    @(posedge clk);
    n = 0; got = 1'b0; busy_bad = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (rsp_valid === 1'b1) got = 1'b1;
      else begin
        if (req_ready !== 1'b0) busy_bad = 1'b1;
        req_we = 1'($urandom); req_addr = AW'($urandom);
        req_funct3 = 3'($urandom); req_wdata = $urandom;
      end
    end
    req_valid = 1'b0;
    rd_obs = rsp_rdata; err_obs = rsp_err;
    chk($sformatf("%s_latency", tag), n, WC + 1);
    chk($sformatf("%s_busy_ready", tag), {31'd0, busy_bad}, 32'd0);
    chk($sformatf("%s_err", tag), {31'd0, rsp_err}, {31'd0, e_err});
    chk($sformatf("%s_rdata", tag), rsp_rdata, e_rd);
    @(negedge clk);
    chk($sformatf("%s_valid_drop", tag), {31'd0, rsp_valid}, 32'd0);
    chk($sformatf("%s_ready_back", tag), {31'd0, req_ready}, 32'd1);
    chk($sformatf("%s_hold", tag), rsp_rdata, e_rd);
  endtask

  // Aborts an SW by raising reset k falling edges after accept (k=WC hits the commit edge).
  task automatic reset_mid(input logic [AW-1:0] a, input logic [31:0] wd, input int k, input string tag);
    bit pulse;
    pulse = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_funct3 = 3'b010; req_wdata = wd;
    @(posedge clk);
    for (int i = 0; i < k; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) pulse = 1'b1;
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (rsp_valid === 1'b1) pulse = 1'b1;
    chk($sformatf("%s_ready_in_reset", tag), {31'd0, req_ready}, 32'd0);
    chk($sformatf("%s_rdata_reset", tag), rsp_rdata, 32'd0);
    chk($sformatf("%s_err_reset", tag), {31'd0, rsp_err}, 32'd0);
    reset = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("%s_ready_after", tag), {31'd0, req_ready}, 32'd1);
    for (int i = 0; i < 2 * WC + 2; i++) begin
      if (rsp_valid === 1'b1) pulse = 1'b1;
      @(negedge clk);
    end
    chk($sformatf("%s_no_pulse", tag), {31'd0, pulse}, 32'd0);
  endtask

  initial begin
    logic [31:0] rd, prior;
    logic er;
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_funct3 = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", {31'd0, rsp_err}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready_after", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 128; i++) txn(1'b1, AW'(i * 4), 3'b010, $urandom, "fill", rd, er);

    txn(1'b1, 9'h010, 3'b010, 32'hDEADBEEF, "sw_beef", rd, er);
    txn(1'b0, 9'h010, 3'b010, 32'h0, "lw_beef", rd, er);
    chk("lw_beef_const", rd, 32'hDEADBEEF);
    chk("lw_beef_err_const", {31'd0, er}, 32'd0);

    txn(1'b1, 9'h010, 3'b010, 32'h11223344, "sw_base", rd, er);
    txn(1'b1, 9'h013, 3'b000, 32'h000000A5, "sb_a5", rd, er);
    txn(1'b0, 9'h013, 3'b000, 32'h0, "lb_a5", rd, er);
    chk("lb_a5_const", rd, 32'hFFFFFFA5);
    txn(1'b0, 9'h013, 3'b100, 32'h0, "lbu_a5", rd, er);
    chk("lbu_a5_const", rd, 32'h000000A5);
    txn(1'b0, 9'h010, 3'b010, 32'h0, "lw_merged", rd, er);
    chk("lw_merged_const", rd, 32'hA5223344);

    txn(1'b1, 9'h022, 3'b001, 32'h00008001, "sh_8001", rd, er);
    txn(1'b0, 9'h022, 3'b001, 32'h0, "lh_8001", rd, er);
    chk("lh_8001_const", rd, 32'hFFFF8001);
    txn(1'b0, 9'h022, 3'b101, 32'h0, "lhu_8001", rd, er);
    chk("lhu_8001_const", rd, 32'h00008001);

    txn(1'b0, 9'h011, 3'b010, 32'h0, "lw_misaligned", rd, er);
`ifdef DMEM_MISALIGN_CHK_EN
    chk("lw_misaligned_rdata_const", rd, 32'h0);
    chk("lw_misaligned_err_const", {31'd0, er}, 32'd1);
`else
    chk("lw_misaligned_rdata_const", rd, 32'hA5223344);
    chk("lw_misaligned_err_const", {31'd0, er}, 32'd0);
`endif

    txn(1'b1, 9'h030, 3'b010, 32'hCAFE0001, "sw_030", rd, er);
    txn(1'b1, 9'h030, 3'b011, 32'h55555555, "bad_store", rd, er);
    chk("bad_store_err_const", {31'd0, er}, 32'd1);
    txn(1'b0, 9'h030, 3'b010, 32'h0, "lw_030", rd, er);
    chk("lw_030_const", rd, 32'hCAFE0001);

    prior = m_mem[16];
    reset_mid(9'h040, 32'h12345678, 1, "rst_wait");
    txn(1'b0, 9'h040, 3'b010, 32'h0, "lw_040", rd, er);
    chk("lw_040_prior", rd, prior);
    prior = m_mem[17];
    reset_mid(9'h044, 32'h87654321, WC, "rst_commit");
    txn(1'b0, 9'h044, 3'b010, 32'h0, "lw_044", rd, er);
    chk("lw_044_prior", rd, prior);

    for (int i = 0; i < 300; i++)
      txn(1'($urandom), AW'($urandom), 3'($urandom), $urandom, "rand", rd, er);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, byte-address width.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, extra wait states per access (legal range 0-15).
REQ-003 SHALL have a word-organized array of 2^(ADDR_W-2) 32-bit words, indexed by req_addr[ADDR_W-1:2].
REQ-004 SHALL have port clk, input, 1, clock; all logic on the rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port req_valid, input, 1, initiator presents a request.
REQ-007 SHALL have port req_ready, output, 1, responder can accept a request.
REQ-008 SHALL have port req_we, input, 1, 1 = store, 0 = load.
REQ-009 SHALL have port req_addr, input, ADDR_W, byte address.
REQ-010 SHALL have port req_funct3, input, 3, RV32I load/store funct3.
REQ-011 SHALL have port req_wdata, input, 32, store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 SHALL have port rsp_valid, output, 1, one-cycle response strobe.
REQ-013 SHALL have port rsp_rdata, output, 32, extended load data.
REQ-014 SHALL have port rsp_err, output, 1, access faulted; qualified by rsp_valid.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 SHALL drive req_ready=1 only in IDLE and not during reset.
REQ-017 SHALL accept a request when req_valid & req_ready; capture we/addr/funct3/wdata; go to WAIT if WAIT_CYCLES>0, else RESP.
REQ-018 SHALL stay in WAIT for exactly WAIT_CYCLES cycles, then go to RESP.
REQ-019 SHALL assert rsp_valid for exactly one cycle in RESP and return to IDLE next cycle: accept at edge N -> rsp_valid high in cycle N+1+WAIT_CYCLES.
REQ-020 SHALL ignore req_valid and all req_* inputs outside IDLE; captured values only.
REQ-021 SHALL commit a store on the edge entering RESP: SB writes lane addr[1:0], SH writes lanes {addr[1],0} and {addr[1],1}, SW writes all lanes; other lanes unchanged.
REQ-022 SHALL register rsp_rdata on the edge entering RESP from the addressed word: LB/LH sign-extend, LBU/LHU zero-extend, LW full word; lanes chosen by addr[1:0].
REQ-023 SHALL drive rsp_rdata=0 for stores and errored accesses; hold rsp_rdata and rsp_err until the next RESP entry.
REQ-024 SHALL treat as error loads with funct3 011/110/111 and stores with funct3 not 000/001/010: rsp_err=1, no write.
REQ-025 SHALL return data written by an earlier completed store to a later load of the same address (no stale read).

Reset
REQ-026 SHALL on reset force state IDLE, wait counter 0, rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0.
REQ-027 SHALL abort an in-flight access if reset is asserted mid-operation; a store whose commit edge coincides with reset SHALL NOT be written.
REQ-028 SHALL NOT clear the memory array on reset.

Configuration
REQ-029 With DMEM_MISALIGN_CHK_EN defined: halfword with addr[0]=1 or word with addr[1:0]!=0 SHALL give rsp_err=1, no write, rsp_rdata=0.
REQ-030 Without DMEM_MISALIGN_CHK_EN: misaligned accesses SHALL be naturally aligned by clearing the low address bits (half: addr[0]; word: addr[1:0]) and complete normally; REQ-024 errors still apply.

Verification
REQ-031 SW addr 0x010 data 0xDEADBEEF, WAIT_CYCLES=2, then LW 0x010 -> each rsp_valid 3 cycles after accept; load rsp_rdata=0xDEADBEEF, rsp_err=0.
REQ-032 SB 0x013 data 0x000000A5 over 0x11223344, then LB 0x013 -> 0xFFFFFFA5; LBU 0x013 -> 0x000000A5; LW 0x010 -> 0xA5223344.
REQ-033 SH 0x022 data 0x8001, then LH 0x022 -> 0xFFFF8001; LHU 0x022 -> 0x00008001.
REQ-034 With macro: LW 0x011 -> rsp_err=1, rsp_rdata=0; without macro: LW 0x011 returns the word at 0x010, rsp_err=0.
REQ-035 Store with funct3=011 to 0x030 -> rsp_err=1; subsequent LW 0x030 unchanged; req_valid held high in WAIT never causes a second accept.
REQ-036 Reset asserted in the WAIT cycle of SW 0x040 data 0x12345678 -> rsp_valid never pulses, req_ready=1 the cycle after reset deasserts, LW 0x040 returns the prior value.
